// File: rtl/hs_npu_postproc_pkg.sv
// Shared types for the NPU post-processing block: the job FSM states and
// the activation-mode encodings carried on cfg_act.
package hs_npu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_MID   = 2'd2,
        ST_LAST  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'b00,
        ACT_RELU  = 2'b01,
        ACT_LEAKY = 2'b10,
        ACT_RSVD  = 2'b11
    } act_e;

    // Leaky activation divides negative values by 8 (arithmetic shift).
    localparam int unsigned LEAKY_SHIFT = 3;

    // Row/tile count as seen by the FSM: zero means one, and an optional
    // upper bound caps the value.
    function automatic logic [7:0] eff_count(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == 8'd0) begin
            r = 8'd1;
        end else if (v > max_v) begin
            r = max_v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/hs_npu_postproc_if.sv
// Streaming handshake bundle: partial-sum rows in, quantized rows out.
interface hs_npu_postproc_if #(
    parameter int LANES     = 8,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16
);
    logic                               in_valid;
    logic                               in_ready;
    logic [LANES-1:0][IN_WIDTH-1:0]     in_data;
    logic                               out_valid;
    logic                               out_ready;
    logic [LANES-1:0][OUT_WIDTH-1:0]    out_data;

    // Producer of partial sums and consumer of results.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The post-processing block itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/hs_npu_postproc_quant.sv
// One-lane quantizer: rounding right shift, activation, then saturation
// of the result to OUT_WIDTH. Purely combinational.
module hs_npu_postproc_quant
    import hs_npu_pkg::*;
#(
    parameter int ACC_WIDTH = 40,
    parameter int OUT_WIDTH = 16
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    input  logic [5:0]                  shift_i,
    input  act_e                        act_i,
    output logic signed [OUT_WIDTH-1:0] q_o,
    output logic                        sat_o
);
    // One guard bit so the rounding increment can never wrap.
    localparam int W1 = ACC_WIDTH + 1;
    localparam logic signed [W1-1:0] ONE_C   = {{(W1-1){1'b0}}, 1'b1};
    localparam logic signed [W1-1:0] OUT_MAX = {{(W1-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [W1-1:0] OUT_MIN = {{(W1-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [31:0]           sh_s;
    logic signed [W1-1:0]  ext_s;
    logic signed [W1-1:0]  rnd_s;
    logic signed [W1-1:0]  shf_s;
    logic signed [W1-1:0]  act_s;

    // Round-half-up shift; shifts at or beyond the accumulator width sign-fill.
    always_comb begin
        sh_s  = {26'd0, shift_i};
        ext_s = {acc_i[ACC_WIDTH-1], acc_i};
        rnd_s = ext_s;
        if (sh_s == 32'd0) begin
            shf_s = ext_s;
        end else if (sh_s >= 32'(ACC_WIDTH)) begin
            shf_s = {W1{acc_i[ACC_WIDTH-1]}};
        end else begin
            rnd_s = ext_s + (ONE_C <<< (sh_s - 32'd1));
            shf_s = rnd_s >>> sh_s;
        end
    end

    // Activation on the shifted value; the reserved code behaves as none.
    always_comb begin
        case (act_i)
            ACT_RELU:  act_s = shf_s[W1-1] ? {W1{1'b0}} : shf_s;
            ACT_LEAKY: act_s = shf_s[W1-1] ? (shf_s >>> LEAKY_SHIFT) : shf_s;
            default:   act_s = shf_s;
        endcase
    end

    // Clamp to the signed output range and flag any clamp.
    always_comb begin
        if (act_s > OUT_MAX) begin
            q_o   = OUT_MAX[OUT_WIDTH-1:0];
            sat_o = 1'b1;
        end else if (act_s < OUT_MIN) begin
            q_o   = OUT_MIN[OUT_WIDTH-1:0];
            sat_o = 1'b1;
        end else begin
            q_o   = act_s[OUT_WIDTH-1:0];
            sat_o = 1'b0;
        end
    end

endmodule

// File: rtl/hs_npu_postproc.sv
// NPU post-processing: accumulates partial-sum rows over T tiles into a
// per-row buffer, then quantizes the final tile and queues the result rows
// in an output FIFO.
module hs_npu_postproc
    import hs_npu_pkg::*;
#(
    parameter int LANES      = 8,
    parameter int IN_WIDTH   = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_WIDTH  = 16,
    parameter int MAX_ROWS   = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               abort,
    input  logic [7:0]                         cfg_rows,
    input  logic [7:0]                         cfg_tiles,
    input  logic [5:0]                         cfg_shift,
    input  logic [1:0]                         cfg_act,
    input  logic [LANES-1:0][ACC_WIDTH-1:0]    bias_i,
    hs_npu_postproc_if.slave                   bus,
    output logic                               busy,
    output logic                               done,
    output logic                               sat_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ROW_W = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
    localparam int SW    = ACC_WIDTH + 1;
    localparam logic [7:0]       MAX_ROWS_C = 8'(MAX_ROWS);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR_C = PTR_W'(FIFO_DEPTH-1);

    typedef logic [LANES-1:0][OUT_WIDTH-1:0] out_row_t;
    typedef logic [LANES-1:0][ACC_WIDTH-1:0] acc_row_t;

    // Saturate an (ACC_WIDTH+1)-bit sum to ACC_WIDTH; MSB of result is the clamp flag.
    function automatic logic [ACC_WIDTH:0] sat_acc(input logic [SW-1:0] v);
        logic [ACC_WIDTH:0] r;
        if (v[SW-1] != v[SW-2]) begin
            r = {1'b1, v[SW-1], {(ACC_WIDTH-1){~v[SW-1]}}};
        end else begin
            r = {1'b0, v[ACC_WIDTH-1:0]};
        end
        return r;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == LAST_PTR_C) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Job state and latched configuration.
    state_e          state_q, state_d;
    logic [7:0]      rows_q, rows_d, tiles_q, tiles_d;
    logic [5:0]      shift_q, shift_d;
    act_e            act_q, act_d;
    acc_row_t        bias_q, bias_d;
    logic [7:0]      row_cnt_q, row_cnt_d, tile_cnt_q, tile_cnt_d;
    logic            sat_q, sat_d, done_q, done_d, busy_q, busy_d;
    logic            in_ready_q, in_ready_d;

    // Output FIFO state.
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    out_row_t         out_data_q, out_data_d;
    out_row_t         fifo_mem [FIFO_DEPTH];

    // Accumulator buffer, one row of lanes per tile row.
    acc_row_t         buf_mem [MAX_ROWS];
    acc_row_t         buf_rd_s;
    logic [ROW_W-1:0] row_idx_s;

    // Datapath nets.
    logic                      xfer_s, use_bias_s, buf_we_s, push_s, push_ok_s, pop_s;
    logic [LANES-1:0][SW-1:0]  sum_s;
    logic [LANES-1:0][ACC_WIDTH:0] sat_pack_s;
    acc_row_t                  acc_val_s;
    logic [LANES-1:0]          acc_sat_s, q_sat_s;
    out_row_t                  q_s;

    assign row_idx_s  = row_cnt_q[ROW_W-1:0];
    assign buf_rd_s   = buf_mem[row_idx_s];
    assign xfer_s     = bus.in_valid && in_ready_q && !abort;
    assign use_bias_s = (state_q == ST_FIRST) || ((state_q == ST_LAST) && (tiles_q == 8'd1));

    // Per-lane sum of the base (bias or buffered partial) with the incoming row.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            if (use_bias_s) begin
                sum_s[l] = {bias_q[l][ACC_WIDTH-1], bias_q[l]}
                         + {{(SW-IN_WIDTH){bus.in_data[l][IN_WIDTH-1]}}, bus.in_data[l]};
            end else begin
                sum_s[l] = {buf_rd_s[l][ACC_WIDTH-1], buf_rd_s[l]}
                         + {{(SW-IN_WIDTH){bus.in_data[l][IN_WIDTH-1]}}, bus.in_data[l]};
            end
            sat_pack_s[l] = sat_acc(sum_s[l]);
            acc_val_s[l]  = sat_pack_s[l][ACC_WIDTH-1:0];
            acc_sat_s[l]  = sat_pack_s[l][ACC_WIDTH];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        hs_npu_postproc_quant #(
            .ACC_WIDTH (ACC_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_quant (
            .acc_i   (acc_val_s[g]),
            .shift_i (shift_q),
            .act_i   (act_q),
            .q_o     (q_s[g]),
            .sat_o   (q_sat_s[g])
        );
    end

    // Job FSM: next state, counters, config capture and sticky saturation.
    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        tiles_d    = tiles_q;
        shift_d    = shift_q;
        act_d      = act_q;
        bias_d     = bias_q;
        row_cnt_d  = row_cnt_q;
        tile_cnt_d = tile_cnt_q;
        sat_d      = sat_q;
        done_d     = 1'b0;
        buf_we_s   = 1'b0;
        push_s     = 1'b0;
        if (abort) begin
            state_d    = ST_IDLE;
            row_cnt_d  = 8'd0;
            tile_cnt_d = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rows_d     = eff_count(cfg_rows, MAX_ROWS_C);
                        tiles_d    = eff_count(cfg_tiles, 8'hFF);
                        shift_d    = cfg_shift;
                        act_d      = act_e'(cfg_act);
                        bias_d     = bias_i;
                        sat_d      = 1'b0;
                        row_cnt_d  = 8'd0;
                        tile_cnt_d = 8'd0;
                        state_d    = (eff_count(cfg_tiles, 8'hFF) == 8'd1) ? ST_LAST : ST_FIRST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FIRST, ST_MID, ST_LAST: begin
                    if (xfer_s) begin
                        if (state_q == ST_LAST) begin
                            push_s = 1'b1;
                            sat_d  = sat_q | (|acc_sat_s) | (|q_sat_s);
                        end else begin
                            buf_we_s = 1'b1;
                            sat_d    = sat_q | (|acc_sat_s);
                        end
                        if (row_cnt_q == (rows_q - 8'd1)) begin
                            row_cnt_d  = 8'd0;
                            tile_cnt_d = tile_cnt_q + 8'd1;
                            if (state_q == ST_LAST) begin
                                state_d    = ST_IDLE;
                                done_d     = 1'b1;
                                tile_cnt_d = 8'd0;
                            end else if ((tile_cnt_q + 8'd1) == (tiles_q - 8'd1)) begin
                                state_d = ST_LAST;
                            end else begin
                                state_d = ST_MID;
                            end
                        end else begin
                            row_cnt_d = row_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // FIFO pointers/count and the registered head row presented on out_data.
    always_comb begin
        pop_s       = out_valid_q && bus.out_ready;
        push_ok_s   = push_s && ((count_q != DEPTH_C) || pop_s);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        if (abort) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            wr_ptr_d = push_ok_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            rd_ptr_d = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            case ({push_ok_s, pop_s})
                2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
            if (count_d != {CNT_W{1'b0}}) begin
                // The new head is the row being written this edge when the queue
                // was otherwise going to be empty.
                if (push_ok_s && (rd_ptr_d == wr_ptr_q)) begin
                    out_data_d = q_s;
                end else begin
                    out_data_d = fifo_mem[rd_ptr_d];
                end
            end else begin
                out_data_d = out_data_q;
            end
        end
        out_valid_d = (count_d != {CNT_W{1'b0}});
        in_ready_d  = (state_d == ST_FIRST) || (state_d == ST_MID)
                   || ((state_d == ST_LAST) && (count_d != DEPTH_C));
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rows_q      <= 8'd1;
            tiles_q     <= 8'd1;
            shift_q     <= 6'd0;
            act_q       <= ACT_NONE;
            bias_q      <= {(LANES*ACC_WIDTH){1'b0}};
            row_cnt_q   <= 8'd0;
            tile_cnt_q  <= 8'd0;
            sat_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {(LANES*OUT_WIDTH){1'b0}};
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            tiles_q     <= tiles_d;
            shift_q     <= shift_d;
            act_q       <= act_d;
            bias_q      <= bias_d;
            row_cnt_q   <= row_cnt_d;
            tile_cnt_q  <= tile_cnt_d;
            sat_q       <= sat_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Accumulator buffer write; FIRST always overwrites, so no reset is needed.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            buf_mem[row_idx_s] <= acc_val_s;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            fifo_mem[wr_ptr_q] <= q_s;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign sat_o         = sat_q;
    assign fifo_count    = count_q;

endmodule

// File: tb/tb_hs_npu_postproc.sv
// Scoreboard bench: the stimulus side queues the hand-computed result for
// every final-tile row it sends; a monitor pops and compares each accepted
// output row.
module tb_hs_npu_postproc;
    import hs_npu_pkg::*;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [7:0]        cfg_rows;
    logic [7:0]        cfg_tiles;
    logic [5:0]        cfg_shift;
    logic [1:0]        cfg_act;
    logic [1:0][39:0]  bias_i;
    logic              busy;
    logic              done;
    logic              sat_o;
    logic [2:0]        fifo_count;

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [31:0]       exp_q[$];

    hs_npu_postproc_if #(.LANES(2), .IN_WIDTH(32), .OUT_WIDTH(16)) bus ();

    hs_npu_postproc #(
        .LANES(2), .IN_WIDTH(32), .ACC_WIDTH(40), .OUT_WIDTH(16),
        .MAX_ROWS(16), .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cfg_rows   (cfg_rows),
        .cfg_tiles  (cfg_tiles),
        .cfg_shift  (cfg_shift),
        .cfg_act    (cfg_act),
        .bias_i     (bias_i),
        .bus        (bus.slave),
        .busy       (busy),
        .done       (done),
        .sat_o      (sat_o),
        .fifo_count (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted output row against the scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_unexpected: got %0h required no output", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 64'(bus.out_data), 64'(e));
                end
            end
        end
    end

    // All tasks below start and end at posedge+1.
    task automatic start_job(input logic [7:0] rows, input logic [7:0] tiles,
                             input logic [5:0] sh, input logic [1:0] act,
                             input logic signed [39:0] b0, input logic signed [39:0] b1);
        cfg_rows  = rows;
        cfg_tiles = tiles;
        cfg_shift = sh;
        cfg_act   = act;
        bias_i[0] = b0;
        bias_i[1] = b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic send_row(input logic signed [31:0] d0, input logic signed [31:0] d1,
                            input bit last, input logic [15:0] e0, input logic [15:0] e1);
        int waitc = 0;
        bus.in_valid   = 1'b1;
        bus.in_data[0] = d0;
        bus.in_data[1] = d1;
        @(negedge clk);
        while (!bus.in_ready && waitc < 200) begin
            waitc++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 required 1 within 200 cycles");
        end else if (last) begin
            exp_q.push_back({e1, e0});
        end else begin
            waitc = 0;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic end_job();
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd1);
        @(negedge clk);
        chk("done_single", 64'(done), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_single(input logic [7:0] rows, input logic [7:0] tiles,
                              input logic [5:0] sh, input logic [1:0] act,
                              input logic signed [39:0] b0, input logic signed [39:0] b1,
                              input logic signed [31:0] d0, input logic signed [31:0] d1,
                              input logic [15:0] e0, input logic [15:0] e1);
        start_job(rows, tiles, sh, act, b0, b1);
        send_row(d0, d1, 1'b1, e0, e1);
        end_job();
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required end of test");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_rows = 8'd0; cfg_tiles = 8'd0; cfg_shift = 6'd0; cfg_act = 2'd0;
        bias_i = {80{1'b0}};
        bus.in_valid = 1'b0; bus.in_data = {64{1'b0}}; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sat", 64'(sat_o), 64'd0);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;

        // Bias add, single tile, single row.
        run_single(8'd1, 8'd1, 6'd0, 2'd0, 40'sd5, -40'sd5, 32'sd10, 32'sd10, 16'sd15, 16'sd5);

        // Three tiles of two rows with rounding shift by one.
        start_job(8'd2, 8'd3, 6'd1, 2'd0, 40'sd0, 40'sd0);
        for (int t = 0; t < 3; t++) begin
            send_row(32'sd1, 32'sd1, (t == 2), 16'sd2, 16'sd2);
            send_row(32'sd2, 32'sd2, (t == 2), 16'sd3, 16'sd3);
        end
        end_job();
        drain();

        // Activations, rounding of negatives, oversized shift, saturation.
        run_single(8'd1, 8'd1, 6'd0, 2'd1, 40'sd0, 40'sd0, -32'sd100, 32'sd7, 16'sd0, 16'sd7);
        chk("sat_clear_relu", 64'(sat_o), 64'd0);
        run_single(8'd1, 8'd1, 6'd0, 2'd2, 40'sd0, 40'sd0, -32'sd100, -32'sd8, -16'sd13, -16'sd1);
        run_single(8'd1, 8'd1, 6'd0, 2'd3, 40'sd0, 40'sd0, -32'sd100, 32'sd5, -16'sd100, 16'sd5);
        run_single(8'd1, 8'd1, 6'd2, 2'd0, 40'sd0, 40'sd0, -32'sd6, 32'sd6, -16'sd1, 16'sd2);
        run_single(8'd1, 8'd1, 6'd45, 2'd0, 40'sd0, 40'sd0, -32'sd6, 32'sd6, -16'sd1, 16'sd0);
        run_single(8'd1, 8'd1, 6'd0, 2'd0, 40'sd0, 40'sd0, 32'sd100000, -32'sd100000, 16'sh7FFF, 16'sh8000);
        chk("sat_set", 64'(sat_o), 64'd1);
        // Zero rows/tiles act as one; the new start clears the sticky flag.
        run_single(8'd0, 8'd0, 6'd0, 2'd0, 40'sd1, 40'sd1, 32'sd9, -32'sd9, 16'sd10, -16'sd8);
        chk("sat_cleared_on_start", 64'(sat_o), 64'd0);

        // FIFO backpressure: depth 4, eight rows, consumer stalled.
        bus.out_ready = 1'b0;
        start_job(8'd8, 8'd1, 6'd0, 2'd0, 40'sd0, 40'sd0);
        for (int i = 0; i < 4; i++) begin
            send_row(32'(i * 10 + 1), 32'(-(i + 1)), 1'b1, 16'(i * 10 + 1), 16'(-(i + 1)));
        end
        @(negedge clk);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("full_count", 64'(fifo_count), 64'd4);
        chk("full_out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 4; i < 8; i++) begin
            send_row(32'(i * 10 + 1), 32'(-(i + 1)), 1'b1, 16'(i * 10 + 1), 16'(-(i + 1)));
        end
        end_job();
        drain();

        // Abort during MID with leftover FIFO rows.
        bus.out_ready = 1'b0;
        start_job(8'd2, 8'd1, 6'd0, 2'd0, 40'sd0, 40'sd0);
        send_row(32'sd3, 32'sd4, 1'b1, 16'sd3, 16'sd4);
        send_row(32'sd5, 32'sd6, 1'b1, 16'sd5, 16'sd6);
        end_job();
        start_job(8'd2, 8'd3, 6'd0, 2'd0, 40'sd0, 40'sd0);
        send_row(32'sd1, 32'sd1, 1'b0, 16'sd0, 16'sd0);
        send_row(32'sd1, 32'sd1, 1'b0, 16'sd0, 16'sd0);
        @(negedge clk);
        chk("pre_abort_count", 64'(fifo_count), 64'd2);
        chk("pre_abort_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        abort = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_count", 64'(fifo_count), 64'd0);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("abort_done_late", 64'(done), 64'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        run_single(8'd1, 8'd1, 6'd0, 2'd0, 40'sd5, -40'sd5, 32'sd10, 32'sd10, 16'sd15, 16'sd5);

        // Reset in the middle of LAST.
        bus.out_ready = 1'b0;
        start_job(8'd4, 8'd1, 6'd0, 2'd0, 40'sd0, 40'sd0);
        send_row(32'sd100000, 32'sd1, 1'b1, 16'sh7FFF, 16'sd1);
        send_row(32'sd2, 32'sd3, 1'b1, 16'sd2, 16'sd3);
        @(negedge clk);
        chk("pre_rst_sat", 64'(sat_o), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_out_data", 64'(bus.out_data), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_sat", 64'(sat_o), 64'd0);
        chk("mid_rst_count", 64'(fifo_count), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // A start while busy must not disturb the running job.
        bus.out_ready = 1'b1;
        start_job(8'd1, 8'd3, 6'd0, 2'd0, 40'sd1, 40'sd2);
        send_row(32'sd10, 32'sd20, 1'b0, 16'sd0, 16'sd0);
        @(negedge clk);
        chk("tile_cnt_before", 64'(dut.tile_cnt_q), 64'd1);
        @(posedge clk); #1;
        start_job(8'd1, 8'd1, 6'd0, 2'd1, 40'sd100, 40'sd100);
        @(negedge clk);
        chk("tile_cnt_after", 64'(dut.tile_cnt_q), 64'd1);
        chk("busy_after_start", 64'(busy), 64'd1);
        @(posedge clk); #1;
        send_row(32'sd10, 32'sd20, 1'b0, 16'sd0, 16'sd0);
        send_row(32'sd10, 32'sd20, 1'b1, 16'sd31, 16'sd62);
        end_job();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hs_npu_postproc.md
HS_NPU_POSTPROC -- requirements
Module: hs_npu_postproc

Interface
REQ-001 Parameter LANES, default 8: lane count, one accumulator/quantizer per lane.
REQ-002 Parameter IN_WIDTH, default 32: signed partial-sum width per lane.
REQ-003 Parameter ACC_WIDTH, default 40: signed accumulator width, at least IN_WIDTH.
REQ-004 Parameter OUT_WIDTH, default 16: signed result width.
REQ-005 Parameter MAX_ROWS, default 16: rows per tile, which sets the accumulator buffer depth.
REQ-006 Parameter FIFO_DEPTH, default 16: output FIFO depth in lane-rows.
REQ-007 Ports, clock and reset first: clk in 1 system clock; rst in 1 reset. One clock; reset is asynchronous and active-high.
REQ-008 start in 1: begin job, accepted only in IDLE; abort in 1: synchronous job cancel.
REQ-009 cfg_rows in 8: rows per tile; cfg_tiles in 8: tiles per job; both sampled at start.
REQ-010 cfg_shift in 6: rounding right-shift; cfg_act in 2: 00 none, 01 ReLU, 10 leaky (x>>>3 when negative), 11 treated as none; both sampled at start.
REQ-011 bias_i in LANES x ACC_WIDTH: per-lane bias, sampled at start.
REQ-012 in_valid in 1; in_ready out 1; in_data in LANES x IN_WIDTH: partial-sum row.
REQ-013 out_valid out 1; out_ready in 1; out_data out LANES x OUT_WIDTH: result row.
REQ-014 busy out 1; done out 1 (one-cycle pulse); sat_o out 1 (sticky saturation flag); fifo_count out clog2(FIFO_DEPTH+1).

Function
REQ-015 FSM states: IDLE, FIRST (tile 0), MID (tiles 1..T-2), LAST (tile T-1). start moves IDLE to FIRST, or to LAST when the effective T is 1.
REQ-016 cfg_rows=0 and cfg_tiles=0 are treated as 1; cfg_rows greater than MAX_ROWS is clamped to MAX_ROWS.
REQ-017 A row transfers when in_valid and in_ready are both high. Each transfer advances row_cnt. When row_cnt reaches rows-1, row_cnt wraps to 0 and tile_cnt increments.
REQ-018 in_ready is 1 in FIRST and MID, is !fifo_full in LAST, and is 0 in IDLE.
REQ-019 FIRST: buf[row][l] is set to sat(bias[l] + in[l]). MID: buf[row][l] is set to sat(buf[row][l] + in[l]).
REQ-020 LAST: s = buf[row][l] + in[l] (or bias + in when T=1). s is then rounded-shifted, activated, saturated to OUT_WIDTH, and pushed to the FIFO on the same edge.
REQ-021 Rounding: when shift > 0, add 1<<(shift-1) before the arithmetic shift. When shift is 0 or at least ACC_WIDTH, the shift is identity or sign-fill respectively.
REQ-022 Saturation clamps to [-2^(W-1), 2^(W-1)-1] at both ACC_WIDTH and OUT_WIDTH. Any clamp sets sat_o; sat_o clears on an accepted start.
REQ-023 Latency: out_valid is high the cycle after a LAST transfer when the FIFO was empty. FIFO order is preserved.
REQ-024 When the FIFO is full, a push occurs only if a pop occurs on the same edge. Simultaneous push and pop leaves fifo_count unchanged.
REQ-025 After the final row of LAST transfers: done pulses for one cycle and the FSM returns to IDLE; the FIFO may still hold data.
REQ-026 busy is 1 in every state except IDLE.
REQ-027 start is ignored outside IDLE.
REQ-028 abort returns the FSM to IDLE, clears the counters and empties the FIFO next cycle; done does not pulse. abort wins over a simultaneous start.
REQ-029 The out_data of a row is held stable while out_valid=1 and out_ready=0.

Reset
REQ-030 On rst: FSM=IDLE, counters=0, FIFO empty, in_ready=0, out_valid=0, busy=0, done=0, sat_o=0, fifo_count=0.
REQ-031 out_data resets to 0. The accumulator buffer is not reset, because FIRST overwrites it.
REQ-032 rst asserted mid-job discards all state; the first start after deassertion behaves as from power-up.

Structure
REQ-033 hs_npu_pkg holds the state enum (IDLE/FIRST/MID/LAST) and the act-mode enum with its encodings.
REQ-034 One sub-module, hs_npu_postproc_quant: combinational, one lane, covering rounding, shift, activation and OUT saturation, instantiated LANES times.
REQ-035 The FIFO is implemented inside the block on a single memory LANES*OUT_WIDTH bits wide.

Verification
REQ-036 LANES=2, T=1, rows=1, bias={5,-5}, in={10,10}, shift=0, act none -> out={15,5}, done pulses once.
REQ-037 T=3, rows=2, bias=0, rows inputs 1,2 per tile on all lanes, shift=1 -> outputs 2 (3 rounded after >>1) then 3.
REQ-038 in=-100, bias=0, T=1: act=01 -> 0; act=10 -> -13; in=100000, shift=0, OUT_WIDTH=16 -> 32767 with sat_o=1.
REQ-039 FIFO_DEPTH=4, rows=8, T=1, out_ready=0 -> in_ready drops after 4 transfers; raising out_ready drains all 8 rows in order.
REQ-040 abort during MID with the FIFO non-empty -> busy=0 and fifo_count=0 next cycle; done stays 0. A new start then completes correctly.
REQ-041 rst pulse mid-LAST -> all outputs match reset values; start asserted while busy -> ignored, as checked by an unchanged tile_cnt.
